// File: rtl/eth_fifo_pkg.sv
// Shared constants and sizing helpers for the Ethernet MAC FIFOs.
// Optional status logic in eth_dpram_fifo is enabled by ETH_FIFO_STATUS_EN.
package eth_fifo_pkg;

  localparam int FIFO_DEPTH_TX = 16;
  localparam int FIFO_DEPTH_RX = 16;
  localparam int FIFO_WIDTH_WB = 32;

  // Occupancy needs one extra bit so that "completely full" is representable.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/eth_dpram.sv
// WIDTH x DEPTH distributed RAM: one synchronous write port with an
// asynchronous read at the write address (spo), plus an asynchronous read-only port (dpo).
module eth_dpram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic [AW-1:0]    ra,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] spo,
  output logic [WIDTH-1:0] dpo
);

  logic [WIDTH-1:0] mem [DEPTH] = '{default: '0};

  // NOTE: the array has no reset branch on purpose; resetting it would turn
  // distributed RAM into DEPTH*WIDTH discrete flops.
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= d;
  end

  assign spo = mem[wa];
  assign dpo = mem[ra];

endmodule

// File: rtl/eth_dpram_fifo.sv
// Show-ahead synchronous FIFO on eth_dpram with occupancy count and almost-full.
// Sticky overflow/underflow flags exist only when ETH_FIFO_STATUS_EN is defined.
module eth_dpram_fifo
  import eth_fifo_pkg::*;
#(
  parameter int WIDTH     = FIFO_WIDTH_WB,
  parameter int DEPTH     = FIFO_DEPTH_TX,
  parameter int CNT_W     = cnt_width(DEPTH),
  parameter int AFULL_LVL = DEPTH - 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             write,
  input  logic [WIDTH-1:0] data_in,
  input  logic             read,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic [CNT_W-1:0] cnt,
  output logic             overflow,
  output logic             underflow
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNT_W-1:0] cnt_q;
  logic             rd_acc;
  logic             wr_acc;
  logic [WIDTH-1:0] spo_unused;

  assign empty       = (cnt_q == '0);
  assign full        = (cnt_q == CNT_W'(DEPTH));
  assign almost_full = (cnt_q >= CNT_W'(AFULL_LVL));
  assign cnt         = cnt_q;

  // A pop frees the slot a same-cycle push needs, so a full FIFO can still
  // accept a push paired with a pop; an empty FIFO never pops.
  assign rd_acc = read & ~empty;
  assign wr_acc = write & (~full | rd_acc);

  eth_dpram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk (clk),
    .we  (wr_acc & ~clear),
    .wa  (wr_ptr),
    .ra  (rd_ptr),
    .d   (data_in),
    .spo (spo_unused),
    .dpo (data_out)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_acc, rd_acc})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

`ifdef ETH_FIFO_STATUS_EN
  logic overflow_q;
  logic underflow_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (clear) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (write & ~wr_acc) overflow_q  <= 1'b1;
      if (read & empty)    underflow_q <= 1'b1;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_eth_dpram_fifo.sv
// Directed self-checking bench for eth_dpram_fifo (DEPTH=16, WIDTH=8, AFULL_LVL=14).
module tb_eth_dpram_fifo;

  localparam int WIDTH     = 8;
  localparam int DEPTH     = 16;
  localparam int AFULL_LVL = 14;
  localparam int CNT_W     = 5;
`ifdef ETH_FIFO_STATUS_EN
  localparam logic STS = 1'b1;
`else
  localparam logic STS = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             clear;
  logic             write;
  logic [WIDTH-1:0] data_in;
  logic             read;
  logic [WIDTH-1:0] data_out;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic [CNT_W-1:0] cnt;
  logic             overflow;
  logic             underflow;

  int total = 0;
  int bad   = 0;

  eth_dpram_fifo #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .AFULL_LVL (AFULL_LVL)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .write       (write),
    .data_in     (data_in),
    .read        (read),
    .data_out    (data_out),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .cnt         (cnt),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [WIDTH-1:0] q[$];
    int mcnt;
    int nwr;
    int j;
    logic do_wr;
    logic do_rd;

    reset = 1'b1; clear = 1'b0; write = 1'b0; read = 1'b0; data_in = '0;
    tick(); tick();
    reset = 1'b0;
    tick();

    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_afull", almost_full, 0);
    check("rst_cnt", cnt, 0);
    check("rst_ovf", overflow, 0);
    check("rst_unf", underflow, 0);

    // Single word write then read.
    write = 1'b1; data_in = 8'hA5;
    tick();
    write = 1'b0;
    check("w1_empty", empty, 0);
    check("w1_cnt", cnt, 1);
    check("w1_dout", data_out, 8'hA5);
    read = 1'b1;
    tick();
    read = 1'b0;
    check("r1_empty", empty, 1);
    check("r1_cnt", cnt, 0);

    // Fill 0x00..0x0F; almost_full rises at count 14.
    for (int i = 0; i < 16; i++) begin
      write = 1'b1; data_in = 8'(i);
      tick();
      if (i == 12) check("afull_at13", almost_full, 0);
      if (i == 13) check("afull_at14", almost_full, 1);
      if (i == 14) check("full_at15", full, 0);
    end
    write = 1'b0;
    check("fill_full", full, 1);
    check("fill_cnt", cnt, 16);
    write = 1'b1; data_in = 8'hFF;
    tick();
    write = 1'b0;
    check("ovf_cnt", cnt, 16);
    check("ovf_flag", overflow, STS);
    for (int i = 0; i < 16; i++) begin
      check("drain_dout", data_out, 32'(i));
      read = 1'b1;
      tick();
    end
    read = 1'b0;
    check("drain_empty", empty, 1);

    // Full FIFO: simultaneous push and pop.
    for (int i = 0; i < 16; i++) begin
      write = 1'b1; data_in = 8'(i);
      tick();
    end
    read = 1'b1; data_in = 8'h55;
    tick();
    write = 1'b0; read = 1'b0;
    check("rw_full_cnt", cnt, 16);
    check("rw_full_dout", data_out, 8'h01);
    for (int i = 1; i < 17; i++) begin
      check("rw_drain", data_out, (i == 16) ? 32'h55 : 32'(i));
      read = 1'b1;
      tick();
    end
    read = 1'b0;
    check("rw_drain_empty", empty, 1);

    // Empty FIFO: simultaneous push and pop, pop rejected.
    write = 1'b1; read = 1'b1; data_in = 8'h33;
    tick();
    write = 1'b0; read = 1'b0;
    check("unf_flag", underflow, STS);
    check("unf_cnt", cnt, 1);
    check("unf_dout", data_out, 8'h33);
    read = 1'b1;
    tick();
    read = 1'b0;
    check("unf_drain_empty", empty, 1);

    // Interleaved traffic, count held between 3 and 5, against a queue model.
    mcnt = 0; nwr = 0; j = 0;
    while (nwr < 40 || mcnt > 0) begin
      do_wr = (nwr < 40) && (mcnt < 5);
      do_rd = (nwr >= 40) ? (mcnt > 0) : ((mcnt > 3) && ((j % 2 == 0) || mcnt == 5));
      write = do_wr; read = do_rd;
      data_in = 8'(nwr * 7 + 3);
      if (do_rd) begin
        check("sb_dout", data_out, q[0]);
        void'(q.pop_front());
        mcnt--;
      end
      if (do_wr) begin
        q.push_back(8'(nwr * 7 + 3));
        nwr++;
        mcnt++;
      end
      tick();
      check("sb_cnt", cnt, 32'(mcnt));
      j++;
    end
    write = 1'b0; read = 1'b0;
    check("sb_empty", empty, 1);

    // Clear beats a same-cycle write.
    for (int i = 0; i < 7; i++) begin
      write = 1'b1; data_in = 8'(8'h40 + i);
      tick();
    end
    write = 1'b0;
    check("pre_clr_cnt", cnt, 7);
    check("pre_clr_ovf", overflow, STS);
    clear = 1'b1; write = 1'b1; data_in = 8'h77;
    tick();
    clear = 1'b0; write = 1'b0;
    check("clr_cnt", cnt, 0);
    check("clr_empty", empty, 1);
    check("clr_ovf", overflow, 0);
    check("clr_unf", underflow, 0);

    // Asynchronous reset in the middle of a burst.
    for (int i = 0; i < 3; i++) begin
      write = 1'b1; data_in = 8'(8'h90 + i);
      tick();
    end
    check("burst_cnt", cnt, 3);
    #2;
    reset = 1'b1; write = 1'b0;
    #1;
    check("arst_cnt", cnt, 0);
    check("arst_empty", empty, 1);
    #1;
    reset = 1'b0;
    tick();
    write = 1'b1; data_in = 8'hA1;
    tick();
    write = 1'b0;
    check("post_rst_cnt", cnt, 1);
    check("post_rst_dout", data_out, 8'hA1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
